// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID->EX pipeline register with operand muxing, two-port forwarding,
// valid/ready hold and a saturating backpressure counter.
module ex_operand_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  logic [XLEN-1:0]        id_pc_i,
  input  logic [XLEN-1:0]        id_rs1_data_i,
  input  logic [XLEN-1:0]        id_rs2_data_i,
  input  logic [XLEN-1:0]        id_imm_i,
  input  logic [4:0]             id_rs1_addr_i,
  input  logic [4:0]             id_rs2_addr_i,
  input  logic [4:0]             id_rd_addr_i,
  input  logic                   id_reg_write_i,
  input  logic [1:0]             id_srca_sel_i,
  input  logic [1:0]             id_srcb_sel_i,
  input  logic [3:0]             id_alu_fun_i,
  input  logic                   fwd1_en_i,
  input  logic [4:0]             fwd1_rd_i,
  input  logic [XLEN-1:0]        fwd1_data_i,
  input  logic                   fwd2_en_i,
  input  logic [4:0]             fwd2_rd_i,
  input  logic [XLEN-1:0]        fwd2_data_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [XLEN-1:0]        ex_op_1_o,
  output logic [XLEN-1:0]        ex_op_2_o,
  output logic [3:0]             ex_alu_fun_o,
  output logic [XLEN-1:0]        ex_rs2_val_o,
  output logic [XLEN-1:0]        ex_pc_o,
  output logic [4:0]             ex_rd_addr_o,
  output logic                   ex_reg_write_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  logic                   ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]        op_1_q, op_1_d, op_2_q, op_2_d, rs2_val_q, pc_q;
  logic [3:0]             alu_fun_q;
  logic [4:0]             rd_addr_q;
  logic                   reg_write_q, reg_write_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]        rs1_fwd, rs2_fwd;
  logic                   accept, load;

  // MEM-stage result is newer than WB, so it wins; x0 is hardwired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] rf);
    return (fwd1_en_i && fwd1_rd_i == a && a != 5'd0) ? fwd1_data_i :
           (fwd2_en_i && fwd2_rd_i == a && a != 5'd0) ? fwd2_data_i : rf;
  endfunction

  always_comb begin
    id_ready_o  = ~ex_valid_q | ex_ready_i;
    accept      = id_valid_i & id_ready_o;
    load        = accept & ~flush_i;
    rs1_fwd     = fwd(id_rs1_addr_i, id_rs1_data_i);
    rs2_fwd     = fwd(id_rs2_addr_i, id_rs2_data_i);
    op_1_d      = id_srca_sel_i == 2'd0 ? rs1_fwd :
                  id_srca_sel_i == 2'd1 ? id_imm_i :
                  id_srca_sel_i == 2'd2 ? id_pc_i : '0;
    op_2_d      = id_srcb_sel_i == 2'd0 ? rs2_fwd :
                  id_srcb_sel_i == 2'd1 ? id_imm_i :
                  id_srcb_sel_i == 2'd2 ? id_pc_i : XLEN'(4);
    reg_write_d = id_reg_write_i & (id_rd_addr_i != 5'd0);
    ex_valid_d  = flush_i ? 1'b0 : accept ? 1'b1 : ex_ready_i ? 1'b0 : ex_valid_q;
    stall_cnt_d = (ex_valid_q & ~ex_ready_i & ~&stall_cnt_q) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_q  <= 1'b0;
      op_1_q      <= '0;
      op_2_q      <= '0;
      rs2_val_q   <= '0;
      pc_q        <= '0;
      alu_fun_q   <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (load) begin
        op_1_q      <= op_1_d;
        op_2_q      <= op_2_d;
        rs2_val_q   <= rs2_fwd;
        pc_q        <= id_pc_i;
        alu_fun_q   <= id_alu_fun_i;
        rd_addr_q   <= id_rd_addr_i;
        reg_write_q <= reg_write_d;
      end
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_op_1_o      = op_1_q;
  assign ex_op_2_o      = op_2_q;
  assign ex_rs2_val_o   = rs2_val_q;
  assign ex_pc_o        = pc_q;
  assign ex_alu_fun_o   = alu_fun_q;
  assign ex_rd_addr_o   = rd_addr_q;
  assign ex_reg_write_o = reg_write_q;
  assign stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: table-driven operand/forwarding vectors plus hand sequences
// for stall hold, flush, counter saturation and asynchronous reset.
module tb_ex_operand_stage;
  logic        clk = 0, rst_n = 0, flush = 0, id_valid = 0, ex_ready = 1;
  logic [31:0] pc = 0, d1 = 0, d2 = 0, imm = 0, f1d = 0, f2d = 0;
  logic [4:0]  a1 = 0, a2 = 0, rd = 0, f1r = 0, f2r = 0;
  logic        rw = 0, f1e = 0, f2e = 0;
  logic [1:0]  sa = 0, sb = 0;
  logic [3:0]  fun = 0;
  logic        id_ready, ex_valid, ex_rw, s_id_ready, s_ex_valid, s_ex_rw;
  logic [31:0] op1, op2, rs2v, ex_pc, s_op1, s_op2, s_rs2v, s_pc;
  logic [3:0]  ex_fun, s_fun;
  logic [4:0]  ex_rd, s_rd;
  logic [15:0] stall;
  logic [3:0]  s_stall;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(pc), .id_rs1_data_i(d1), .id_rs2_data_i(d2), .id_imm_i(imm),
    .id_rs1_addr_i(a1), .id_rs2_addr_i(a2), .id_rd_addr_i(rd), .id_reg_write_i(rw),
    .id_srca_sel_i(sa), .id_srcb_sel_i(sb), .id_alu_fun_i(fun),
    .fwd1_en_i(f1e), .fwd1_rd_i(f1r), .fwd1_data_i(f1d),
    .fwd2_en_i(f2e), .fwd2_rd_i(f2r), .fwd2_data_i(f2d),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_op_1_o(op1), .ex_op_2_o(op2),
    .ex_alu_fun_o(ex_fun), .ex_rs2_val_o(rs2v), .ex_pc_o(ex_pc), .ex_rd_addr_o(ex_rd),
    .ex_reg_write_o(ex_rw), .stall_cnt_o(stall));

  ex_operand_stage #(.XLEN(32), .STALL_CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(s_id_ready),
    .id_pc_i(pc), .id_rs1_data_i(d1), .id_rs2_data_i(d2), .id_imm_i(imm),
    .id_rs1_addr_i(a1), .id_rs2_addr_i(a2), .id_rd_addr_i(rd), .id_reg_write_i(rw),
    .id_srca_sel_i(sa), .id_srcb_sel_i(sb), .id_alu_fun_i(fun),
    .fwd1_en_i(f1e), .fwd1_rd_i(f1r), .fwd1_data_i(f1d),
    .fwd2_en_i(f2e), .fwd2_rd_i(f2r), .fwd2_data_i(f2d),
    .ex_valid_o(s_ex_valid), .ex_ready_i(ex_ready), .ex_op_1_o(s_op1), .ex_op_2_o(s_op2),
    .ex_alu_fun_o(s_fun), .ex_rs2_val_o(s_rs2v), .ex_pc_o(s_pc), .ex_rd_addr_o(s_rd),
    .ex_reg_write_o(s_ex_rw), .stall_cnt_o(s_stall));

  typedef struct {
    logic [1:0] sa, sb; logic [4:0] a1, a2, rd; logic rw; logic [3:0] fun;
    logic [31:0] d1, d2, imm, pc;
    logic f1e; logic [4:0] f1r; logic [31:0] f1d;
    logic f2e; logic [4:0] f2r; logic [31:0] f2d;
    logic [31:0] e1, e2, ers2; logic erw;
  } vec_t;

  vec_t v [8];
  vec_t va, vb, vc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    sa = x.sa; sb = x.sb; a1 = x.a1; a2 = x.a2; rd = x.rd; rw = x.rw; fun = x.fun;
    d1 = x.d1; d2 = x.d2; imm = x.imm; pc = x.pc;
    f1e = x.f1e; f1r = x.f1r; f1d = x.f1d; f2e = x.f2e; f2r = x.f2r; f2d = x.f2d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{0,1,1,2,7,1,0,  32'h5,32'h9,32'h7,32'h10,   0,0,0,        0,0,0,        32'h5,32'h7,32'h9,1};
    v[1] = '{0,0,3,4,8,1,2,  32'h11,32'h22,0,32'h14,     1,3,32'hAA,   1,3,32'hBB,   32'hAA,32'h22,32'h22,1};
    v[2] = '{0,0,3,4,8,1,3,  32'h11,32'h22,0,32'h18,     0,3,32'hAA,   1,3,32'hBB,   32'hBB,32'h22,32'h22,1};
    v[3] = '{0,0,0,0,9,1,4,  0,0,0,32'h1c,               1,0,32'hAA,   1,0,32'hBB,   0,0,0,1};
    v[4] = '{2,3,1,2,0,1,5,  1,2,3,32'h100,              0,0,0,        0,0,0,        32'h100,32'h4,32'h2,0};
    v[5] = '{3,2,1,2,10,0,6, 1,2,3,32'h200,              0,0,0,        0,0,0,        0,32'h200,32'h2,0};
    v[6] = '{1,0,1,5,11,1,7, 1,2,32'h30,32'h204,         1,6,32'hDD,   1,5,32'hCC,   32'h30,32'hCC,32'hCC,1};
    v[7] = '{0,0,5,5,12,1,15,1,2,3,32'h208,              1,5,32'hEE,   1,5,32'hCC,   32'hEE,32'hEE,32'hEE,1};
    va   = '{1,0,1,2,3,1,1,  0,0,32'h55,32'h300,         0,0,0,        0,0,0,        32'h55,0,0,1};
    vb   = '{1,0,1,2,4,1,2,  0,0,32'h66,32'h304,         0,0,0,        0,0,0,        32'h66,0,0,1};
    vc   = '{1,0,1,2,5,1,3,  0,0,32'h77,32'h308,         0,0,0,        0,0,0,        32'h77,0,0,1};

    #12;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_fun", 32'(ex_fun), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      apply(v[i]); id_valid = 1; ex_ready = 1;
      step();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("v%0d_op1", i), op1, v[i].e1);
      chk($sformatf("v%0d_op2", i), op2, v[i].e2);
      chk($sformatf("v%0d_rs2", i), rs2v, v[i].ers2);
      chk($sformatf("v%0d_pc", i), ex_pc, v[i].pc);
      chk($sformatf("v%0d_fun", i), 32'(ex_fun), 32'(v[i].fun));
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(v[i].rd));
      chk($sformatf("v%0d_rw", i), 32'(ex_rw), 32'(v[i].erw));
    end

    id_valid = 0; step();
    chk("drain_valid", 32'(ex_valid), 32'd0);
    chk("drain_op1_kept", op1, 32'hEE);

    apply(va); id_valid = 1; step();
    chk("a_op1", op1, 32'h55);
    apply(vb); ex_ready = 0; #1;
    chk("stall_id_ready", 32'(id_ready), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("stall_valid", 32'(ex_valid), 32'd1);
    chk("stall_op1_held", op1, 32'h55);
    chk("stall_pc_held", ex_pc, 32'h300);
    chk("stall_rd_held", 32'(ex_rd), 32'd3);
    chk("stall_cnt4", 32'(stall), 32'd4);
    chk("stall_id_ready2", 32'(id_ready), 32'd0);
    ex_ready = 1; step();
    chk("b_valid", 32'(ex_valid), 32'd1);
    chk("b_op1", op1, 32'h66);
    chk("b_pc", ex_pc, 32'h304);
    chk("b_stall_cnt", 32'(stall), 32'd4);

    apply(vc); flush = 1; step();
    flush = 0; id_valid = 0;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_op1_kept", op1, 32'h66);
    chk("flush_pc_kept", ex_pc, 32'h304);

    apply(va); id_valid = 1; step();
    id_valid = 0; ex_ready = 0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt16", 32'(stall), 32'd24);
    chk("sat_cnt4", 32'(s_stall), 32'd15);
    chk("sat_valid", 32'(ex_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_cnt16", 32'(stall), 32'd0);
    chk("arst_cnt4", 32'(s_stall), 32'd0);
    chk("arst_op1", op1, 32'd0);
    chk("arst_id_ready", 32'(id_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
